freq_lock_monitor: RTL and testbench

FREQ_LOCK_MONITOR -- requirements
Module: freq_lock_monitor

---
 rtl/freq_mon_pkg.sv | 16 +
 rtl/freq_mon_channel.sv | 122 ++++++++++++
 rtl/freq_lock_monitor.sv | 68 ++++++
 tb/tb_freq_lock_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_mon_pkg.sv
// Shared types and default parameter values for the frequency lock monitor.
package freq_mon_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam int DEF_NCH      = 2;
    localparam int DEF_WIN_CYC  = 256;
    localparam int DEF_CNT_W    = 12;
    localparam int DEF_TOL      = 1;
    localparam int DEF_LOCK_N   = 4;
    localparam int DEF_UNLOCK_N = 2;

endpackage

// File: rtl/freq_mon_channel.sv
// One monitored channel: tick counter, per-window tolerance compare and a
// two-state lock FSM with saturating good/bad streak counters.
module freq_mon_channel
    import freq_mon_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_N   = DEF_LOCK_N,
    parameter int UNLOCK_N = DEF_UNLOCK_N
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_win_end,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_expected,
    output logic [CNT_W-1:0] o_meas,
    output logic             o_good,
    output logic             o_locked,
    output logic             o_lock_lost
);

    localparam int GS_W = $clog2(LOCK_N + 1);
    localparam int BS_W = $clog2(UNLOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);
    localparam logic [GS_W-1:0]  GS_SAT  = GS_W'(LOCK_N);
    localparam logic [BS_W-1:0]  BS_SAT  = BS_W'(UNLOCK_N);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic t);
        if (t && (c != CNT_MAX)) return c + 1'b1;
        return c;
    endfunction

    // A pinned counter means the true count is unknown, so it is never good.
    function automatic logic within_tol(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] e);
        logic signed [CNT_W:0] diff;
        logic        [CNT_W:0] mag;
        diff = $signed({1'b0, c}) - $signed({1'b0, e});
        mag  = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        return (c != CNT_MAX) && (mag <= TOL_V);
    endfunction

    logic [CNT_W-1:0] r_cnt_p0;
    logic [CNT_W-1:0] w_cnt_next_p0;
    logic             w_good_now_p0;
    logic [CNT_W-1:0] r_meas_p1;
    logic             r_good_p1;
    logic [GS_W-1:0]  r_gs, w_gs_next;
    logic [BS_W-1:0]  r_bs, w_bs_next;
    lock_state_e      r_state, w_state_next;
    logic             w_drop;
    logic             r_lock_lost_p1;

    assign w_cnt_next_p0 = sat_inc(r_cnt_p0, i_tick);
    assign w_good_now_p0 = within_tol(w_cnt_next_p0, i_expected);

    always_ff @(posedge i_clock) begin
        if (i_reset || !i_enable || i_win_end) r_cnt_p0 <= '0;
        else                                   r_cnt_p0 <= w_cnt_next_p0;
    end

    // ---- stage p0 -> p1: window result capture ----
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meas_p1 <= '0;
            r_good_p1 <= 1'b0;
        end else if (i_win_end) begin
            r_meas_p1 <= w_cnt_next_p0;
            r_good_p1 <= w_good_now_p0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= UNLOCKED;
            r_gs    <= '0;
            r_bs    <= '0;
        end else begin
            r_state <= w_state_next;
            r_gs    <= w_gs_next;
            r_bs    <= w_bs_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gs_next    = r_gs;
        w_bs_next    = r_bs;
        if (!i_enable) begin
            w_state_next = UNLOCKED;
            w_gs_next    = '0;
            w_bs_next    = '0;
        end else if (i_win_end) begin
            if (w_good_now_p0) begin
                w_bs_next = '0;
                w_gs_next = (r_gs == GS_SAT) ? r_gs : r_gs + 1'b1;
                if ((r_state == UNLOCKED) && (w_gs_next == GS_SAT)) w_state_next = LOCKED;
            end else begin
                w_gs_next = '0;
                w_bs_next = (r_bs == BS_SAT) ? r_bs : r_bs + 1'b1;
                if ((r_state == LOCKED) && (w_bs_next == BS_SAT)) w_state_next = UNLOCKED;
            end
        end
    end

    // Disabling drops lock silently; only a bad-streak drop is reported.
    always_comb begin
        o_locked = (r_state == LOCKED);
        w_drop   = i_enable && (r_state == LOCKED) && (w_state_next == UNLOCKED);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) r_lock_lost_p1 <= 1'b0;
        else         r_lock_lost_p1 <= w_drop;
    end

    assign o_meas      = r_meas_p1;
    assign o_good      = r_good_p1;
    assign o_lock_lost = r_lock_lost_p1;

endmodule

// File: rtl/freq_lock_monitor.sv
// Multi-channel frequency lock monitor: one shared measurement window
// drives NCH independent channel counters and lock FSMs.
module freq_lock_monitor
    import freq_mon_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int WIN_CYC  = DEF_WIN_CYC,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_N   = DEF_LOCK_N,
    parameter int UNLOCK_N = DEF_UNLOCK_N
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NCH-1:0]       fb_tick,
    input  logic [NCH*CNT_W-1:0] expected,
    output logic [NCH*CNT_W-1:0] meas,
    output logic                 meas_valid,
    output logic [NCH-1:0]       good,
    output logic [NCH-1:0]       locked,
    output logic [NCH-1:0]       lock_lost
);

    localparam int WIN_W = $clog2(WIN_CYC);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);

    logic [WIN_W-1:0] r_win_cnt_p0;
    logic             w_win_end_p0;
    logic             r_meas_valid_p1;

    assign w_win_end_p0 = enable && (r_win_cnt_p0 == WIN_LAST);

    always_ff @(posedge clock) begin
        if (reset || !enable)  r_win_cnt_p0 <= '0;
        else if (w_win_end_p0) r_win_cnt_p0 <= '0;
        else                   r_win_cnt_p0 <= r_win_cnt_p0 + 1'b1;
    end

    // ---- stage p0 -> p1: window-end strobe ----
    always_ff @(posedge clock) begin
        if (reset) r_meas_valid_p1 <= 1'b0;
        else       r_meas_valid_p1 <= w_win_end_p0;
    end

    assign meas_valid = r_meas_valid_p1;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        freq_mon_channel #(
            .CNT_W    (CNT_W),
            .TOL      (TOL),
            .LOCK_N   (LOCK_N),
            .UNLOCK_N (UNLOCK_N)
        ) u_ch (
            .i_clock     (clock),
            .i_reset     (reset),
            .i_enable    (enable),
            .i_win_end   (w_win_end_p0),
            .i_tick      (fb_tick[ch]),
            .i_expected  (expected[ch*CNT_W +: CNT_W]),
            .o_meas      (meas[ch*CNT_W +: CNT_W]),
            .o_good      (good[ch]),
            .o_locked    (locked[ch]),
            .o_lock_lost (lock_lost[ch])
        );
    end

endmodule

// File: tb/tb_freq_lock_monitor.sv
// Scoreboard bench: window-level reference model feeds a queue that a
// free-running monitor drains on every meas_valid.
module tb_freq_lock_monitor;

    localparam int NCH  = 2;
    localparam int WIN  = 64;
    localparam int CW   = 8;
    localparam int TOL  = 1;
    localparam int LN   = 4;
    localparam int UN   = 2;
    localparam int EXPV = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset, enable;
    logic [NCH-1:0]      fb_tick;
    logic [NCH*CW-1:0]   expected;
    logic [NCH*CW-1:0]   meas;
    logic                meas_valid;
    logic [NCH-1:0]      good, locked, lock_lost;

    logic                enable6;
    logic [1:0]          tick6;
    logic [11:0]         expected6;
    logic [11:0]         meas6;
    logic                mv6;
    logic [1:0]          good6, locked6, lost6;

    freq_lock_monitor #(
        .NCH(NCH), .WIN_CYC(WIN), .CNT_W(CW), .TOL(TOL), .LOCK_N(LN), .UNLOCK_N(UN)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .fb_tick(fb_tick),
        .expected(expected), .meas(meas), .meas_valid(meas_valid),
        .good(good), .locked(locked), .lock_lost(lock_lost)
    );

    freq_lock_monitor #(
        .NCH(2), .WIN_CYC(WIN), .CNT_W(6), .TOL(TOL), .LOCK_N(LN), .UNLOCK_N(UN)
    ) dut6 (
        .clock(clock), .reset(reset), .enable(enable6), .fb_tick(tick6),
        .expected(expected6), .meas(meas6), .meas_valid(mv6),
        .good(good6), .locked(locked6), .lock_lost(lost6)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        int         m0;
        int         m1;
        logic [1:0] g;
        logic [1:0] l;
        logic [1:0] lost;
    } item_t;

    item_t sb[$];
    item_t it;

    // Reference model state, one entry per channel.
    int gs[NCH];
    int bs[NCH];
    bit lk[NCH];
    int last_meas[NCH];
    bit last_good[NCH];
    int ph[NCH];
    int tglob;

    function automatic void model_clear();
        for (int ch = 0; ch < NCH; ch++) begin
            gs[ch] = 0;
            bs[ch] = 0;
            lk[ch] = 1'b0;
        end
    endfunction

    function automatic void eval(input int ch, input int cnt, output int m, output bit g, output bit lost);
        int d;
        m    = (cnt > MAXC) ? MAXC : cnt;
        d    = (m > EXPV) ? m - EXPV : EXPV - m;
        g    = (m != MAXC) && (d <= TOL);
        lost = 1'b0;
        if (g) begin
            bs[ch] = 0;
            if (gs[ch] < LN) gs[ch]++;
            if (!lk[ch] && gs[ch] == LN) lk[ch] = 1'b1;
        end else begin
            gs[ch] = 0;
            if (bs[ch] < UN) bs[ch]++;
            if (lk[ch] && bs[ch] == UN) begin
                lk[ch] = 1'b0;
                lost   = 1'b1;
            end
        end
        last_meas[ch] = m;
        last_good[ch] = g;
    endfunction

    // mode 0: random ~25% density; mode 99: ticks only at first and last window cycle;
    // otherwise a periodic tick every <mode> cycles.
    function automatic logic tick_of(input int mode, input int ch, input int c);
        if (mode == 0)  return ($urandom_range(0, 3) == 0);
        if (mode == 99) return (c == 0) || (c == WIN - 1);
        return ((tglob + ph[ch]) % mode) == 0;
    endfunction

    task automatic drive_cycles(input int n, input int mode0, input int mode1, output int c0, output int c1);
        logic [1:0] t;
        c0 = 0;
        c1 = 0;
        for (int c = 0; c < n; c++) begin
            t[0]    = tick_of(mode0, 0, c);
            t[1]    = tick_of(mode1, 1, c);
            enable  = 1'b1;
            fb_tick = t;
            c0 += int'(t[0]);
            c1 += int'(t[1]);
            tglob++;
            @(posedge clock);
            #1;
        end
        fb_tick = '0;
    endtask

    task automatic run_window(input int mode0, input int mode1);
        int    c0, c1;
        item_t x;
        bit    g0, g1, l0, l1;
        drive_cycles(WIN, mode0, mode1, c0, c1);
        eval(0, c0, x.m0, g0, l0);
        eval(1, c1, x.m1, g1, l1);
        x.cyc  = cyc;
        x.g    = {g1, g0};
        x.l    = {lk[1], lk[0]};
        x.lost = {l1, l0};
        sb.push_back(x);
    endtask

    always @(negedge clock) begin
        if (meas_valid) begin
            if (sb.size() == 0) begin
                check("spurious_meas_valid", 32'(meas_valid), 32'd0);
            end else begin
                it = sb.pop_front();
                check("valid_cycle", cyc, it.cyc);
                check("meas0", 32'(meas[CW-1:0]), it.m0);
                check("meas1", 32'(meas[2*CW-1:CW]), it.m1);
                check("good", 32'(good), 32'(it.g));
                check("locked", 32'(locked), 32'(it.l));
                check("lock_lost", 32'(lock_lost), 32'(it.lost));
            end
        end else begin
            check("lost_outside_eval", 32'(lock_lost), 32'd0);
        end
    end

    initial begin
        int c0, c1;
        reset     = 1'b1;
        enable    = 1'b0;
        fb_tick   = '0;
        expected  = {8'(EXPV), 8'(EXPV)};
        enable6   = 1'b0;
        tick6     = '0;
        expected6 = {6'd16, 6'd63};
        repeat (3) @(posedge clock);
        #1;
        check("rst_meas", 32'(meas), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_good", 32'(good), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_lock_lost", 32'(lock_lost), 32'd0);
        check("rst_meas6", 32'(meas6), 32'd0);

        reset = 1'b0;
        model_clear();
        tglob = 0;
        for (int ch = 0; ch < NCH; ch++) ph[ch] = $urandom_range(0, 11);
        @(posedge clock);
        #1;

        // ch0 at period 4 locks, ch1 at period 5 never does
        repeat (6) run_window(4, 5);
        // ch0 speeds up to period 3 and loses lock on the second bad window
        repeat (3) run_window(3, 0);
        repeat (5) run_window(4, 0);

        // reset in the middle of a window while ch0 is locked
        check("locked_before_reset", 32'(locked[0]), 32'(lk[0]));
        drive_cycles(30, 4, 5, c0, c1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        check("midrst_meas", 32'(meas), 32'd0);
        check("midrst_meas_valid", 32'(meas_valid), 32'd0);
        check("midrst_good", 32'(good), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_lock_lost", 32'(lock_lost), 32'd0);
        repeat (5) run_window(4, 5);

        // disable: lock clears silently, results hold
        check("locked_before_disable", 32'(locked[0]), 32'(lk[0]));
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fb_tick = 2'($urandom_range(0, 3));
            @(posedge clock);
            #1;
            check("dis_locked", 32'(locked), 32'd0);
            check("dis_meas0", 32'(meas[CW-1:0]), last_meas[0]);
            check("dis_meas1", 32'(meas[2*CW-1:CW]), last_meas[1]);
            check("dis_good", 32'(good), 32'({last_good[1], last_good[0]}));
        end
        fb_tick = '0;
        model_clear();

        // constant ticks, then ticks straddling the window boundary
        repeat (2) run_window(1, 1);
        repeat (2) run_window(99, 99);
        repeat (2) run_window(4, 99);
        enable = 1'b0;

        // 6-bit instance: 64 ticks pin the counter at 63, judged bad even when expected=63
        enable6 = 1'b1;
        tick6   = 2'b11;
        repeat (WIN) @(posedge clock);
        #1;
        check("sat_valid", 32'(mv6), 32'd1);
        check("sat_meas", 32'(meas6), 32'({6'd63, 6'd63}));
        check("sat_good", 32'(good6), 32'd0);
        enable6 = 1'b0;
        tick6   = '0;

        repeat (4) @(posedge clock);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
